store_write_buffer: RTL and testbench

Posted-write FIFO between the store unit and data memory. Captures each store request (address, byte-aligned data, byte-lane mask) in one cycle so the pipeline continues. Drains entries in order to the data-memory port over a req/ack handshake. Flags loads that hit a pending store so the pipeline holds the load until that store has drained.

---
 rtl/store_write_buffer.sv | 91 +++++++++
 tb/tb_store_write_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO between the store unit and data memory.
// Stores are captured in one cycle and drained in order over mem_req/mem_ack.
// Loads whose word address matches any buffered store raise ld_hazard_out.
module store_write_buffer #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          wr_req_in,
  input  logic [31:0]   wr_addr_in,
  input  logic [31:0]   wr_data_in,
  input  logic [3:0]    wr_mask_in,
  output logic          stall_out,
  input  logic          ld_req_in,
  input  logic [31:0]   ld_addr_in,
  output logic          ld_hazard_out,
  output logic          mem_req_out,
  output logic [31:0]   mem_addr_out,
  output logic [31:0]   mem_data_out,
  output logic [3:0]    mem_mask_out,
  input  logic          mem_ack_in,
  output logic [CW-1:0] count_out,
  output logic          empty_out,
  output logic          full_out
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  ent_t             ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             enq, deq, has_mask;
  logic [DEPTH-1:0] hit;

  // Full/empty come from the registered count only, so a same-cycle
  // dequeue never opens a slot for a store presented while full.
  assign has_mask  = |wr_mask_in;
  assign full_out  = (cnt_q == CW'(DEPTH));
  assign empty_out = (cnt_q == '0);
  assign count_out = cnt_q;
  assign stall_out = wr_req_in & has_mask & full_out;
  assign enq       = wr_req_in & has_mask & ~full_out;
  assign deq       = mem_req_out & mem_ack_in;

  // Head entry straight from storage: no path from wr_* to mem_*.
  assign mem_req_out  = ~empty_out;
  assign mem_addr_out = ent_q[rptr_q].addr;
  assign mem_data_out = ent_q[rptr_q].data;
  assign mem_mask_out = ent_q[rptr_q].mask;

  // Per-entry word-address compare; only currently valid entries count,
  // so a store being enqueued this cycle is not seen yet.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = vld_q[i] & (ent_q[i].addr[31:2] == ld_addr_in[31:2]);
  end
  assign ld_hazard_out = ld_req_in & (|hit);

  // Storage, valid bits, pointers and count. Enqueue and dequeue never hit
  // the same slot: equal pointers imply empty (no deq) or full (no enq).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) begin
        ent_q[wptr_q] <= '{addr: wr_addr_in, data: wr_data_in, mask: wr_mask_in};
        vld_q[wptr_q] <= 1'b1;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (deq) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          wr_req_in;
  logic [31:0]   wr_addr_in, wr_data_in;
  logic [3:0]    wr_mask_in;
  logic          stall_out;
  logic          ld_req_in;
  logic [31:0]   ld_addr_in;
  logic          ld_hazard_out;
  logic          mem_req_out;
  logic [31:0]   mem_addr_out, mem_data_out;
  logic [3:0]    mem_mask_out;
  logic          mem_ack_in;
  logic [CW-1:0] count_out;
  logic          empty_out, full_out;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  ent_t sb_q[$];
  int   model_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .wr_mask_in(wr_mask_in), .stall_out(stall_out),
    .ld_req_in(ld_req_in), .ld_addr_in(ld_addr_in), .ld_hazard_out(ld_hazard_out),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_mask_out(mem_mask_out), .mem_ack_in(mem_ack_in),
    .count_out(count_out), .empty_out(empty_out), .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  // Scoreboard: stores the model accepts are pushed; each completed
  // handshake pops the oldest and compares it with the presented head.
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1) begin
      automatic logic exp_stall = wr_req_in && (wr_mask_in != 0) && (model_cnt == DEPTH);
      automatic logic acc = wr_req_in && (wr_mask_in != 0) && (model_cnt != DEPTH);
      automatic logic dq  = (model_cnt != 0) && mem_ack_in;
      n_cmp++;
      if (stall_out !== exp_stall) begin
        n_bad++; $display("FAIL stall: got %b want %b (t=%0t)", stall_out, exp_stall, $time);
      end
      n_cmp++;
      if (count_out !== CW'(model_cnt)) begin
        n_bad++; $display("FAIL count: got %0d want %0d (t=%0t)", count_out, model_cnt, $time);
      end
      n_cmp++;
      if (mem_req_out !== (model_cnt != 0)) begin
        n_bad++; $display("FAIL mem_req: got %b want %b (t=%0t)", mem_req_out, model_cnt != 0, $time);
      end
      if (dq) begin
        automatic ent_t e = sb_q.pop_front();
        n_cmp++;
        if ({mem_addr_out, mem_data_out, mem_mask_out} !== e) begin
          n_bad++;
          $display("FAIL drain: got %h/%h/%h want %h/%h/%h", mem_addr_out, mem_data_out,
                   mem_mask_out, e.addr, e.data, e.mask);
        end
      end
      if (acc) sb_q.push_back('{addr: wr_addr_in, data: wr_data_in, mask: wr_mask_in});
      model_cnt = model_cnt + int'(acc) - int'(dq);
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_req_in = 1'b1; wr_addr_in = a; wr_data_in = d; wr_mask_in = m;
  endtask

  // Ack until the buffer empties, with a cycle bound.
  task automatic wait_empty();
    bit done = 0;
    mem_ack_in = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_in);
      if (empty_out === 1'b1) done = 1;
      else tick();
    end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL drain_timeout: got count %0d want 0", count_out); end
    tick();
    mem_ack_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; wr_req_in = 0; wr_addr_in = 0; wr_data_in = 0; wr_mask_in = 0;
    ld_req_in = 0; ld_addr_in = 0; mem_ack_in = 0;
    @(negedge clk_in);
    n_cmp++;
    if ({mem_req_out, mem_addr_out, mem_data_out, mem_mask_out, count_out, empty_out,
         full_out, stall_out, ld_hazard_out} !== {1'b0, 32'h0, 32'h0, 4'h0, CW'(0), 1'b1,
         1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset_state: got req=%b cnt=%0d empty=%b", mem_req_out, count_out, empty_out);
    end
    tick(); rst_n_in = 1'b1;
  endtask

  task automatic test_single();
    store(32'h0000_0104, 32'h0000_AB00, 4'b0010);
    tick(); wr_req_in = 0; mem_ack_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if ({mem_req_out, mem_addr_out, mem_data_out, mem_mask_out} !==
        {1'b1, 32'h0000_0104, 32'h0000_AB00, 4'b0010}) begin
      n_bad++; $display("FAIL single_head: got %b %h %h %b", mem_req_out, mem_addr_out, mem_data_out, mem_mask_out);
    end
    tick(); mem_ack_in = 1'b0;
    @(negedge clk_in);
    n_cmp++;
    if (empty_out !== 1'b1 || count_out !== CW'(0)) begin
      n_bad++; $display("FAIL single_empty: got empty=%b cnt=%0d want 1/0", empty_out, count_out);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      store(32'h10 + 32'(4 * i), 32'hA5A5_0000 ^ 32'(i), 4'hF);
      if (i == 4) begin
        @(negedge clk_in);
        n_cmp++;
        if (full_out !== 1'b1 || stall_out !== 1'b1) begin
          n_bad++; $display("FAIL full_stall: got full=%b stall=%b want 1/1", full_out, stall_out);
        end
      end
      if (i < 4) tick();
    end
    tick(); mem_ack_in = 1'b1;  // 5th store still held
    @(negedge clk_in);
    n_cmp++;
    if (stall_out !== 1'b1 || mem_addr_out !== 32'h10) begin
      n_bad++; $display("FAIL full_ack_cycle: got stall=%b head=%h want 1/10", stall_out, mem_addr_out);
    end
    tick();
    @(negedge clk_in);
    n_cmp++;
    if (stall_out !== 1'b0 || mem_addr_out !== 32'h14) begin
      n_bad++; $display("FAIL full_accept5: got stall=%b head=%h want 0/14", stall_out, mem_addr_out);
    end
    tick(); wr_req_in = 0;
    wait_empty();
  endtask

  task automatic test_hazard();
    store(32'h200, 32'h1234_0000, 4'b1100);
    tick();
    store(32'h300, 32'h0000_5678, 4'b0011); ld_req_in = 1; ld_addr_in = 32'h300;
    @(negedge clk_in);
    n_cmp++;
    if (ld_hazard_out !== 1'b0) begin n_bad++; $display("FAIL haz_enq_same_cycle: got %b want 0", ld_hazard_out); end
    tick(); wr_req_in = 0;
    @(negedge clk_in);
    n_cmp++;
    if (ld_hazard_out !== 1'b1) begin n_bad++; $display("FAIL haz_300: got %b want 1", ld_hazard_out); end
    tick(); ld_addr_in = 32'h202;
    @(negedge clk_in);
    n_cmp++;
    if (ld_hazard_out !== 1'b1) begin n_bad++; $display("FAIL haz_202: got %b want 1", ld_hazard_out); end
    tick(); ld_addr_in = 32'h204;
    @(negedge clk_in);
    n_cmp++;
    if (ld_hazard_out !== 1'b0) begin n_bad++; $display("FAIL haz_204: got %b want 0", ld_hazard_out); end
    tick(); ld_addr_in = 32'h202; ld_req_in = 0;
    @(negedge clk_in);
    n_cmp++;
    if (ld_hazard_out !== 1'b0) begin n_bad++; $display("FAIL haz_noreq: got %b want 0", ld_hazard_out); end
    tick(); ld_req_in = 1; mem_ack_in = 1;  // head 0x200 acked this cycle
    @(negedge clk_in);
    n_cmp++;
    if (ld_hazard_out !== 1'b1) begin n_bad++; $display("FAIL haz_head_acking: got %b want 1", ld_hazard_out); end
    tick(); mem_ack_in = 0;
    @(negedge clk_in);
    n_cmp++;
    if (ld_hazard_out !== 1'b0) begin n_bad++; $display("FAIL haz_after_drain: got %b want 0", ld_hazard_out); end
    tick(); ld_req_in = 0;
    wait_empty();
  endtask

  task automatic test_zero_mask();
    store(32'h80, 32'hFFFF_FFFF, 4'b0000);
    tick(); wr_req_in = 0;
    @(negedge clk_in);
    n_cmp++;
    if (count_out !== CW'(0)) begin n_bad++; $display("FAIL zmask_empty: got cnt=%0d want 0", count_out); end
    tick();
    for (int i = 0; i < 4; i++) begin
      store(32'h400 + 32'(4 * i), 32'(i * 7), 4'b0001);
      tick();
    end
    store(32'h500, 32'hDEAD_BEEF, 4'b0000);
    @(negedge clk_in);
    n_cmp++;
    if (stall_out !== 1'b0 || full_out !== 1'b1) begin
      n_bad++; $display("FAIL zmask_full: got stall=%b full=%b want 0/1", stall_out, full_out);
    end
    tick(); wr_req_in = 0;
    @(negedge clk_in);
    n_cmp++;
    if (count_out !== CW'(4)) begin n_bad++; $display("FAIL zmask_cnt: got %0d want 4", count_out); end
    tick();
    wait_empty();
  endtask

  task automatic test_back_to_back();
    mem_ack_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      store(32'h1000 + 32'(4 * i), $urandom, 4'(i % 15 + 1));
      if (i > 0) begin
        @(negedge clk_in);
        n_cmp++;
        if (count_out !== CW'(1)) begin n_bad++; $display("FAIL b2b_cnt%0d: got %0d want 1", i, count_out); end
      end
      tick();
    end
    wr_req_in = 0;
    wait_empty();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      store(32'h600 + 32'(4 * i), 32'h0BAD_0000 | 32'(i), 4'hF);
      tick();
    end
    wr_req_in = 0; ld_req_in = 1; ld_addr_in = 32'h604;
    @(negedge clk_in); #2;
    rst_n_in = 1'b0;
    sb_q.delete(); model_cnt = 0;
    #1;
    n_cmp++;
    if ({mem_req_out, mem_addr_out, mem_data_out, mem_mask_out, count_out, empty_out,
         full_out, stall_out, ld_hazard_out} !== {1'b0, 32'h0, 32'h0, 4'h0, CW'(0), 1'b1,
         1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL async_reset: got req=%b addr=%h cnt=%0d haz=%b", mem_req_out, mem_addr_out, count_out, ld_hazard_out);
    end
    tick(); rst_n_in = 1'b1; ld_req_in = 0; mem_ack_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (mem_req_out !== 1'b0 || empty_out !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_stale: got req=%b empty=%b want 0/1", mem_req_out, empty_out);
    end
    tick(); mem_ack_in = 1'b0;
    store(32'h40, 32'hCAFE_F00D, 4'b1001);
    tick(); wr_req_in = 0;
    @(negedge clk_in);
    n_cmp++;
    if (mem_addr_out !== 32'h40) begin n_bad++; $display("FAIL post_reset_head: got %h want 40", mem_addr_out); end
    tick();
    wait_empty();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_hazard();
    test_zero_mask();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
